// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths and index type
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;
  localparam int CNT_W    = 2;

  typedef logic [ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write counters, stall and pending_any (REGFILE_BYPASS_EN)
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rc,
  input  logic              use_a,
  input  logic              use_b,
  input  logic              use_c,
  input  logic [ADDR_W-1:0] rw,
  input  logic              reg_w,
  input  logic              issue,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic              pending_any
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [NREGS];

  logic             w_retire;
  logic             w_accept;
  logic             w_full;
  logic [CNT_W-1:0] w_eff_a;
  logic [CNT_W-1:0] w_eff_b;
  logic [CNT_W-1:0] w_eff_c;

  // A write-back only retires when something was actually pending on rw
  always_comb begin
    w_retire = reg_w && (r_cnt[rw] != '0);
  end

`ifdef REGFILE_BYPASS_EN
  // Same-cycle retire is forwarded by the read port, so it no longer counts as a hazard
  always_comb begin
    w_eff_a = r_cnt[ra] - ((w_retire && (rw == ra)) ? CNT_W'(1) : '0);
    w_eff_b = r_cnt[rb] - ((w_retire && (rw == rb)) ? CNT_W'(1) : '0);
    w_eff_c = r_cnt[rc] - ((w_retire && (rw == rc)) ? CNT_W'(1) : '0);
  end
`else
  // Without forwarding the stored value is stale until the edge after the retire
  always_comb begin
    w_eff_a = r_cnt[ra];
    w_eff_b = r_cnt[rb];
    w_eff_c = r_cnt[rc];
  end
`endif

  // Hazard detection: read-after-pending-write or a saturated destination counter
  always_comb begin
    w_full   = issue_wr && (r_cnt[issue_rd] == CNT_MAX) && !(w_retire && (rw == issue_rd));
    stall    = issue && ((use_a && (w_eff_a != '0)) ||
                         (use_b && (w_eff_b != '0)) ||
                         (use_c && (w_eff_c != '0)) ||
                         w_full);
    w_accept = issue && issue_wr && !stall;
  end

  // Counter update: +1 on accepted issue, -1 on retire, both on one index cancel out
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!clear) begin
        r_cnt[i] <= '0;
      end else if (w_accept && (issue_rd == ADDR_W'(i)) && !(w_retire && (rw == ADDR_W'(i)))) begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end else if (w_retire && (rw == ADDR_W'(i)) && !(w_accept && (issue_rd == ADDR_W'(i)))) begin
        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Any write still in flight anywhere
  always_comb begin
    pending_any = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      pending_any = pending_any | (r_cnt[i] != '0);
    end
  end

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - register file, write-back port and read muxes (REGFILE_BYPASS_EN)
module reg_file_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rc,
  input  logic              use_a,
  input  logic              use_b,
  input  logic              use_c,
  output logic [DATA_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_b,
  output logic [DATA_W-1:0] bus_c,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] bus_w,
  input  logic              reg_w,
  input  logic              issue,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              stall,
  output logic              pending_any
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  // Write port is never gated by stall; a frozen write-back just rewrites the same value
  always_ff @(posedge clk) begin
    if (!clear) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (reg_w) begin
      r_regs[rw] <= bus_w;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Read ports forward the write-back value when it targets the same index
  always_comb begin
    bus_a = (reg_w && (rw == ra)) ? bus_w : r_regs[ra];
    bus_b = (reg_w && (rw == rb)) ? bus_w : r_regs[rb];
    bus_c = (reg_w && (rw == rc)) ? bus_w : r_regs[rc];
  end
`else
  // Read ports return stored contents only
  always_comb begin
    bus_a = r_regs[ra];
    bus_b = r_regs[rb];
    bus_c = r_regs[rc];
  end
`endif

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk         (clk),
    .clear       (clear),
    .ra          (ra),
    .rb          (rb),
    .rc          (rc),
    .use_a       (use_a),
    .use_b       (use_b),
    .use_c       (use_c),
    .rw          (rw),
    .reg_w       (reg_w),
    .issue       (issue),
    .issue_wr    (issue_wr),
    .issue_rd    (issue_rd),
    .stall       (stall),
    .pending_any (pending_any)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - randomized scoreboard bench for reg_file_wb (REGFILE_BYPASS_EN)
module tb_reg_file_wb;
  import cpu_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        clear;
    logic [3:0]  ra, rb, rc;
    logic        use_a, use_b, use_c;
    logic [3:0]  rw;
    logic [31:0] bus_w;
    logic        reg_w;
    logic        issue, issue_wr;
    logic [3:0]  issue_rd;
  } stim_t;

  typedef struct {
    logic [31:0] a, b, c;
    logic        stall, pend;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear;
  reg_idx_t    ra, rb, rc, rw, issue_rd;
  logic        use_a, use_b, use_c, reg_w, issue, issue_wr;
  logic [31:0] bus_a, bus_b, bus_c, bus_w;
  logic        stall, pending_any;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  logic [31:0] m_regs [16];
  int          m_cnt  [16];

  reg_file_wb dut (
    .clk(clk), .clear(clear),
    .ra(ra), .rb(rb), .rc(rc),
    .use_a(use_a), .use_b(use_b), .use_c(use_c),
    .bus_a(bus_a), .bus_b(bus_b), .bus_c(bus_c),
    .rw(rw), .bus_w(bus_w), .reg_w(reg_w),
    .issue(issue), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .stall(stall), .pending_any(pending_any)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s.clear = 1'b1; s.ra = '0; s.rb = '0; s.rc = '0;
    s.use_a = 1'b0; s.use_b = 1'b0; s.use_c = 1'b0;
    s.rw = '0; s.bus_w = '0; s.reg_w = 1'b0;
    s.issue = 1'b0; s.issue_wr = 1'b0; s.issue_rd = '0;
    return s;
  endfunction

  function automatic logic [31:0] rd_exp(input int idx, input stim_t s);
    if (BYP && s.reg_w && (int'(s.rw) == idx)) return s.bus_w;
    return m_regs[idx];
  endfunction

  function automatic bit busy(input bit use_x, input int idx, input stim_t s);
    int eff;
    eff = m_cnt[idx];
    if (BYP && s.reg_w && (int'(s.rw) == idx) && eff > 0) eff = eff - 1;
    return use_x && (eff > 0);
  endfunction

  task automatic drive(input stim_t s, input bit push);
    exp_t e;
    bit   full, acc, ret;
    @(posedge clk);
    #1;
    clear = s.clear; ra = s.ra; rb = s.rb; rc = s.rc;
    use_a = s.use_a; use_b = s.use_b; use_c = s.use_c;
    rw = s.rw; bus_w = s.bus_w; reg_w = s.reg_w;
    issue = s.issue; issue_wr = s.issue_wr; issue_rd = s.issue_rd;
    e.a = rd_exp(int'(s.ra), s);
    e.b = rd_exp(int'(s.rb), s);
    e.c = rd_exp(int'(s.rc), s);
    full = s.issue_wr && (m_cnt[s.issue_rd] == 3) && !(s.reg_w && s.rw == s.issue_rd);
    e.stall = s.issue && (busy(s.use_a, int'(s.ra), s) || busy(s.use_b, int'(s.rb), s) ||
                          busy(s.use_c, int'(s.rc), s) || full);
    e.pend = 1'b0;
    for (int i = 0; i < 16; i++) if (m_cnt[i] > 0) e.pend = 1'b1;
    if (push) exp_q.push_back(e);
    if (!s.clear) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] = '0;
        m_cnt[i]  = 0;
      end
    end else begin
      acc = s.issue && s.issue_wr && !e.stall;
      ret = s.reg_w && (m_cnt[s.rw] > 0);
      if (s.reg_w) m_regs[s.rw] = s.bus_w;
      if (acc) m_cnt[s.issue_rd] = m_cnt[s.issue_rd] + 1;
      if (ret) m_cnt[s.rw] = m_cnt[s.rw] - 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("bus_a", bus_a, e.a);
      chk("bus_b", bus_b, e.b);
      chk("bus_c", bus_c, e.c);
      chk("stall", {31'b0, stall}, {31'b0, e.stall});
      chk("pending_any", {31'b0, pending_any}, {31'b0, e.pend});
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.clear = 1'b0;
    clear = 1'b0; ra = '0; rb = '0; rc = '0; use_a = 0; use_b = 0; use_c = 0;
    rw = '0; bus_w = '0; reg_w = 0; issue = 0; issue_wr = 0; issue_rd = '0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = '0; m_cnt[i] = 0; end
    drive(s, 1'b0);

    // Post-reset read of every index
    for (int i = 0; i < 16; i++) begin
      s = idle(); s.ra = 4'(i); s.rb = 4'(i + 1); s.rc = 4'(i + 2);
      drive(s, 1'b1);
    end

    // Write R5 and read it same cycle and next
    s = idle(); s.reg_w = 1; s.rw = 4'd5; s.bus_w = 32'hDEADBEEF; s.ra = 4'd5; drive(s, 1'b1);
    s = idle(); s.ra = 4'd5; drive(s, 1'b1);

    // RAW hazard on R3 released by retire
    s = idle(); s.issue = 1; s.issue_wr = 1; s.issue_rd = 4'd3; drive(s, 1'b1);
    s = idle(); s.issue = 1; s.rb = 4'd3; s.use_b = 1; drive(s, 1'b1);
    s.reg_w = 1; s.rw = 4'd3; s.bus_w = 32'h0000_0033; drive(s, 1'b1);
    s = idle(); s.issue = 1; s.rb = 4'd3; s.use_b = 1; drive(s, 1'b1);

    // Saturate R7, over-subscribe, then over-subscribe with retire
    for (int k = 0; k < 4; k++) begin
      s = idle(); s.issue = 1; s.issue_wr = 1; s.issue_rd = 4'd7; drive(s, 1'b1);
    end
    s.reg_w = 1; s.rw = 4'd7; s.bus_w = 32'h7777_0001; drive(s, 1'b1);
    s = idle(); s.issue = 1; s.issue_wr = 1; s.issue_rd = 4'd7; drive(s, 1'b1);
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.reg_w = 1; s.rw = 4'd7; s.bus_w = 32'h7777_0010 + 32'(k); drive(s, 1'b1);
    end
    s = idle(); drive(s, 1'b1);

    // Cancel-out on R2, no underflow on R9
    s = idle(); s.issue = 1; s.issue_wr = 1; s.issue_rd = 4'd2; drive(s, 1'b1);
    s.reg_w = 1; s.rw = 4'd2; s.bus_w = 32'h2222; drive(s, 1'b1);
    s = idle(); s.reg_w = 1; s.rw = 4'd9; s.bus_w = 32'h9999; drive(s, 1'b1);
    s = idle(); s.issue = 1; s.ra = 4'd2; s.use_a = 1; s.rb = 4'd9; s.use_b = 1; drive(s, 1'b1);
    s = idle(); s.reg_w = 1; s.rw = 4'd2; s.bus_w = 32'h2223; drive(s, 1'b1);
    s = idle(); s.ra = 4'd2; s.rb = 4'd9; drive(s, 1'b1);

    // Mid-flight reset drops R4 pending writes, late write-back still lands
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.issue = 1; s.issue_wr = 1; s.issue_rd = 4'd4; drive(s, 1'b1);
    end
    s = idle(); s.clear = 0; s.ra = 4'd4; drive(s, 1'b1);
    s = idle(); s.ra = 4'd4; drive(s, 1'b1);
    s = idle(); s.reg_w = 1; s.rw = 4'd4; s.bus_w = 32'h11; s.ra = 4'd4; drive(s, 1'b1);
    s = idle(); s.ra = 4'd4; s.issue = 1; s.use_a = 1; drive(s, 1'b1);

    // Randomized traffic on a narrow index range to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      s.clear    = ($urandom_range(0, 99) != 0);
      s.ra       = 4'($urandom_range(0, 7));
      s.rb       = 4'($urandom_range(0, 7));
      s.rc       = 4'($urandom_range(0, 15));
      s.use_a    = 1'($urandom_range(0, 1));
      s.use_b    = 1'($urandom_range(0, 1));
      s.use_c    = 1'($urandom_range(0, 1));
      s.rw       = 4'($urandom_range(0, 7));
      s.bus_w    = $urandom;
      s.reg_w    = 1'($urandom_range(0, 1));
      s.issue    = ($urandom_range(0, 9) < 7);
      s.issue_wr = ($urandom_range(0, 9) < 7);
      s.issue_rd = 4'($urandom_range(0, 7));
      drive(s, 1'b1);
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending expectations required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
